apb_master_arbiter: RTL and testbench

- Shares one APB master port (PSEL/PENABLE/PWRITE/PADDR/PWDATA out; PRDATA/PREADY/PSLVERR in) between NUM_REQ local requesters.
- Arbitrates round-robin and sequences the APB SETUP and ACCESS phases.
- Handles wait states, slave errors and a watchdog timeout.
- Sits between the testbench/firmware-side request agents and the APB slave interface.

---
 rtl/apb_master_arbiter.sv | 161 ++++++++++++++++
 tb/tb_apb_master_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_arbiter.sv
// Round-robin arbiter sharing one APB master port among NUM_REQ requesters; grant -> SETUP next cycle,
// rsp_valid 3 cycles after grant plus wait states; requesters hold req_valid/payload until their req_ready strobe.
module apb_master_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                       PCLK,
  input  logic                       PRESETn,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ-1:0]         req_write,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [NUM_REQ-1:0]         rsp_valid,
  output logic [DATA_W-1:0]          rsp_rdata,
  output logic                       rsp_err,
  output logic                       PSEL,
  output logic                       PENABLE,
  output logic                       PWRITE,
  output logic [ADDR_W-1:0]          PADDR,
  output logic [DATA_W-1:0]          PWDATA,
  input  logic [DATA_W-1:0]          PRDATA,
  input  logic                       PREADY,
  input  logic                       PSLVERR
);

  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam bit TO_EN = (TIMEOUT > 0);
  localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

  logic [1:0]    state;
  logic [GW-1:0] last_grant;
  logic [GW-1:0] owner;
  logic [TW-1:0] tcnt;

  logic          arb_en;
  logic          found;
  logic          grant;
  logic [GW-1:0] winner;
  logic [GW-1:0] cand;
  logic          done;
  logic          abort;

  // Arbitration only happens when the port is free or about to be freed this cycle.
  assign arb_en = PRESETn && ((state == ST_IDLE) || ((state == ST_ACCESS) && PREADY));
  assign grant  = arb_en && found;
  assign done   = (state == ST_ACCESS) && PREADY;
  assign abort  = TO_EN && (state == ST_ACCESS) && !PREADY && (tcnt == T_LAST);

  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = GW'((int'(last_grant) + k) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (grant) begin
      req_ready[winner] = 1'b1;
    end
  end

  assign PSEL    = (state == ST_SETUP) || (state == ST_ACCESS);
  assign PENABLE = (state == ST_ACCESS);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant) begin
            state <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          state <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (PREADY) begin
            state <= grant ? ST_SETUP : ST_IDLE;
          end else if (abort) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Wait-state counter: cleared whenever a new transfer enters SETUP.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      tcnt <= '0;
    end else if (grant) begin
      tcnt <= '0;
    end else if ((state == ST_ACCESS) && !PREADY && !abort) begin
      tcnt <= tcnt + 1'b1;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      last_grant <= GW'(NUM_REQ - 1);
      owner      <= '0;
      PWRITE     <= 1'b0;
      PADDR      <= '0;
      PWDATA     <= '0;
    end else if (grant) begin
      last_grant <= winner;
      owner      <= winner;
      PWRITE     <= req_write[winner];
      PADDR      <= req_addr[int'(winner)*ADDR_W +: ADDR_W];
      // Reads leave the last write data on the bus.
      if (req_write[winner]) begin
        PWDATA <= req_wdata[int'(winner)*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= '0;
      if (done) begin
        rsp_valid[owner] <= 1'b1;
        rsp_rdata        <= PWRITE ? '0 : PRDATA;
        rsp_err          <= PSLVERR;
      end else if (abort) begin
        rsp_valid[owner] <= 1'b1;
        rsp_rdata        <= '0;
        rsp_err          <= 1'b1;
      end
    end
  end

  a_ready_onehot: assert property (@(posedge PCLK) disable iff (!PRESETn) $onehot0(req_ready));
  a_rsp_onehot:   assert property (@(posedge PCLK) disable iff (!PRESETn) $onehot0(rsp_valid));
  a_setup_access: assert property (@(posedge PCLK) disable iff (!PRESETn)
                                   (state == ST_SETUP) |=> (state == ST_ACCESS));

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Scoreboard bench for apb_master_arbiter: a slave model with programmable wait/error/hang,
// expected responses queued at grant time and compared when rsp_valid fires.
module tb_apb_master_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic            PCLK = 1'b0;
  logic            PRESETn = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_write = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_err;
  logic            PSEL, PENABLE, PWRITE;
  logic [AW-1:0]   PADDR;
  logic [DW-1:0]   PWDATA, PRDATA;
  logic            PREADY, PSLVERR;

  apb_master_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  // Slave model
  int            slv_wait = 0;
  logic          slv_hang = 1'b0;
  logic          slv_err  = 1'b0;
  logic [DW-1:0] slv_rdata = '0;
  int            wcnt;

  always @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) wcnt <= 0;
    else if (PENABLE && !PREADY) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end
  assign PREADY  = PENABLE && !slv_hang && (wcnt == slv_wait);
  assign PRDATA  = slv_rdata ^ PADDR;
  assign PSLVERR = slv_err;

  typedef struct {
    int            owner;
    logic [DW-1:0] rdata;
    logic          err;
  } exp_t;

  exp_t exp_q[$];
  int   gnt_log[$];
  int   pend[N];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   rsp_cnt = 0;

  logic [N-1:0]  s_ready, s_rsp_valid;
  logic [DW-1:0] s_rsp_rdata, s_pwdata;
  logic [AW-1:0] s_paddr;
  logic          s_rsp_err, s_psel, s_pen, s_pwrite;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic issue(input int i, input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input int cnt);
    pend[i] = cnt;
    req_write[i] = w;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
    req_valid[i] = 1'b1;
  endtask

  // One clock: sample/score at negedge, then retire granted requests just after posedge.
  task automatic tick();
    logic [N-1:0] g;
    exp_t e;
    @(negedge PCLK);
    cyc++;
    s_ready = req_ready; s_rsp_valid = rsp_valid; s_rsp_rdata = rsp_rdata; s_rsp_err = rsp_err;
    s_psel = PSEL; s_pen = PENABLE; s_paddr = PADDR; s_pwrite = PWRITE; s_pwdata = PWDATA;
    g = req_ready;
    if (g != '0) check("ready_onehot", 64'($onehot(g)), 64'd1);
    for (int i = 0; i < N; i++) begin
      if (g[i]) begin
        e.owner = i;
        if (slv_hang) begin
          e.rdata = '0;
          e.err   = 1'b1;
        end else begin
          e.rdata = req_write[i] ? '0 : (slv_rdata ^ req_addr[i*AW +: AW]);
          e.err   = slv_err;
        end
        exp_q.push_back(e);
        gnt_log.push_back(i);
      end
    end
    if (rsp_valid != '0) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 64'(rsp_valid), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("rsp_owner", 64'(rsp_valid), 64'd1 << e.owner);
        check("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
        check("rsp_err", 64'(rsp_err), 64'(e.err));
        rsp_cnt++;
      end
    end
    @(posedge PCLK);
    #1;
    for (int i = 0; i < N; i++) begin
      if (g[i]) begin
        pend[i]--;
        if (pend[i] <= 0) begin
          req_valid[i] = 1'b0;
        end else begin
          req_write[i] = ~req_write[i];
          req_addr[i*AW +: AW]  = req_addr[i*AW +: AW] + 32'd4;
          req_wdata[i*DW +: DW] = req_wdata[i*DW +: DW] + 32'd1;
        end
      end
    end
  endtask

  // Ticks until rsp_valid is seen; lat is the cycle index of the response relative to the first tick.
  task automatic wait_rsp(input string tag, input int budget, output int lat, output int pen_cnt);
    int n;
    n = 0;
    pen_cnt = 0;
    do begin
      tick();
      n++;
      if (s_pen) pen_cnt++;
    end while (s_rsp_valid == '0 && n < budget);
    lat = n - 1;
    if (s_rsp_valid == '0) check({tag, "_budget"}, 64'd0, 64'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

  initial begin
    int lat, pc, c, bad, start;

    // Reset state, with requests pending during reset
    PRESETn = 1'b0;
    req_valid = '1;
    repeat (2) @(negedge PCLK);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_psel", 64'(PSEL), 64'd0);
    check("rst_penable", 64'(PENABLE), 64'd0);
    check("rst_pwrite", 64'(PWRITE), 64'd0);
    check("rst_paddr", 64'(PADDR), 64'd0);
    check("rst_pwdata", 64'(PWDATA), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    check("rst_rsp_err", 64'(rsp_err), 64'd0);
    req_valid = '0;
    @(posedge PCLK);
    #1 PRESETn = 1'b1;

    // Single zero-wait write, cycle by cycle
    issue(0, 1'b1, 32'h10, 32'hA5A5_0001, 1);
    tick();
    check("t1_c0_ready", 64'(s_ready), 64'h1);
    check("t1_c0_psel", 64'(s_psel), 64'd0);
    tick();
    check("t1_c1_psel", 64'(s_psel), 64'd1);
    check("t1_c1_pen", 64'(s_pen), 64'd0);
    check("t1_c1_paddr", 64'(s_paddr), 64'h10);
    check("t1_c1_pwrite", 64'(s_pwrite), 64'd1);
    check("t1_c1_pwdata", 64'(s_pwdata), 64'hA5A5_0001);
    tick();
    check("t1_c2_pen", 64'(s_pen), 64'd1);
    tick();
    check("t1_c3_rsp_valid", 64'(s_rsp_valid), 64'h1);
    check("t1_c3_rsp_err", 64'(s_rsp_err), 64'd0);
    check("t1_c3_psel", 64'(s_psel), 64'd0);

    // Read with 3 wait states from requester 3
    slv_wait = 3;
    slv_rdata = 32'hDEAD_BEEF ^ 32'h24;
    issue(3, 1'b0, 32'h24, 32'h5555_0000, 1);
    tick();
    check("t2_ready", 64'(s_ready), 64'h8);
    lat = 0; pc = 0; bad = 0;
    do begin
      tick();
      lat++;
      if (s_psel && s_paddr != 32'h24) bad++;
      if (s_psel && s_pwdata != 32'hA5A5_0001) bad++;
      if (s_pen) pc++;
    end while (s_rsp_valid == '0 && lat < 20);
    check("t2_latency", 64'(lat), 64'd6);
    check("t2_access_cycles", 64'(pc), 64'd4);
    check("t2_bus_stable", 64'(bad), 64'd0);
    check("t2_rdata", 64'(s_rsp_rdata), 64'hDEAD_BEEF);
    check("t2_rsp_valid", 64'(s_rsp_valid), 64'h8);

    // Fairness: all four valid for two transfers each, back to back
    slv_wait = 0;
    slv_rdata = 32'h1234_0000;
    gnt_log.delete();
    for (int i = 0; i < N; i++) issue(i, i[0], 32'h100 + 32'(i * 16), 32'hB000_0000 + 32'(i), 2);
    start = rsp_cnt; c = 0; pc = 0;
    while (rsp_cnt < start + 8 && c < 60) begin
      tick();
      c++;
      if (s_psel) pc++;
    end
    check("t3_cycles", 64'(c), 64'd18);
    check("t3_psel_cycles", 64'(pc), 64'd16);
    check("t3_grants", 64'(gnt_log.size()), 64'd8);
    for (int k = 0; k < 8 && k < gnt_log.size(); k++) check("t3_order", 64'(gnt_log[k]), 64'(k % 4));

    // Slave error on a read from requester 2
    slv_err = 1'b1;
    slv_rdata = 32'hCAFE_0000;
    issue(2, 1'b0, 32'h200, 32'h0, 1);
    wait_rsp("t4", 20, lat, pc);
    check("t4_latency", 64'(lat), 64'd3);
    check("t4_rsp_valid", 64'(s_rsp_valid), 64'h4);
    check("t4_rsp_err", 64'(s_rsp_err), 64'd1);
    slv_err = 1'b0;

    // Watchdog abort, then a normal transfer
    slv_hang = 1'b1;
    issue(1, 1'b0, 32'h300, 32'h0, 1);
    wait_rsp("t5", 40, lat, pc);
    check("t5_latency", 64'(lat), 64'd18);
    check("t5_access_cycles", 64'(pc), 64'd16);
    check("t5_rsp_valid", 64'(s_rsp_valid), 64'h2);
    check("t5_rsp_err", 64'(s_rsp_err), 64'd1);
    check("t5_rsp_rdata", 64'(s_rsp_rdata), 64'd0);
    check("t5_psel_after", 64'(s_psel), 64'd0);
    slv_hang = 1'b0;
    issue(0, 1'b1, 32'h304, 32'h77, 1);
    wait_rsp("t5b", 20, lat, pc);
    check("t5b_latency", 64'(lat), 64'd3);
    check("t5b_rsp_err", 64'(s_rsp_err), 64'd0);

    // Reset during ACCESS
    slv_wait = 5;
    issue(2, 1'b0, 32'h400, 32'h0, 1);
    tick(); tick(); tick();
    check("t6_in_access", 64'(s_pen), 64'd1);
    PRESETn = 1'b0;
    #1;
    check("t6_psel_async", 64'(PSEL), 64'd0);
    check("t6_pen_async", 64'(PENABLE), 64'd0);
    exp_q.delete();
    req_valid = '0;
    for (int i = 0; i < N; i++) pend[i] = 0;
    tick();
    check("t6_no_rsp_a", 64'(s_rsp_valid), 64'd0);
    tick();
    check("t6_no_rsp_b", 64'(s_rsp_valid), 64'd0);
    PRESETn = 1'b1;
    slv_wait = 0;
    gnt_log.delete();
    for (int i = 0; i < N; i++) issue(i, 1'b1, 32'h500 + 32'(i * 4), 32'hC0 + 32'(i), 1);
    start = rsp_cnt; c = 0;
    while (rsp_cnt < start + 4 && c < 40) begin
      tick();
      c++;
    end
    check("t6_grants", 64'(gnt_log.size()), 64'd4);
    for (int k = 0; k < 4 && k < gnt_log.size(); k++) check("t6_order", 64'(gnt_log[k]), 64'(k));

    tick();
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
